// File: rtl/periph_bus_initiator.sv
// periph_bus_initiator: takes one CPU request at a time, runs it as a single
// peripheral bus transaction and hands back a write ack or the read data.
module periph_bus_initiator #(
  parameter int READ_LATENCY = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_write,
  input  logic [3:0] req_addr,
  input  logic [7:0] req_wdata,
  output logic       resp_valid,
  input  logic       resp_ready,
  output logic       resp_write,
  output logic [7:0] resp_rdata,
  output logic [3:0] periph_address,
  output logic [7:0] periph_din,
  output logic       periph_writeEnable,
  input  logic [7:0] periph_dout
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    RESP  = 2'd3
  } state_t;

  // Counter reload: READ lasts READ_LATENCY cycles, ending on the cycle where
  // the counter reads zero.
  localparam logic [3:0] LAT_M1 = 4'(READ_LATENCY - 1);

  state_t     state, state_nxt;
  logic [3:0] cnt;
  logic       req_hs;
  logic       cnt_zero;

  assign req_hs   = req_valid && req_ready;
  assign cnt_zero = (cnt == 4'd0);

  // State register; reset aborts any in-flight transaction.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_nxt  = state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    case (state)
      IDLE: begin
        req_ready = !reset;
        if (req_hs) state_nxt = req_write ? WRITE : READ;
      end
      WRITE: state_nxt = RESP;
      READ:  if (cnt_zero) state_nxt = RESP;
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Bus drive and response registers. Bus lines are loaded on acceptance so
  // they are valid during WRITE/READ and simply hold afterwards; din only
  // moves on writes so a read never disturbs it.
  always_ff @(posedge clk) begin
    if (reset) begin
      periph_address     <= 4'd0;
      periph_din         <= 8'd0;
      periph_writeEnable <= 1'b0;
      resp_write         <= 1'b0;
      resp_rdata         <= 8'd0;
      cnt                <= 4'd0;
    end else begin
      periph_writeEnable <= 1'b0;
      case (state)
        IDLE: begin
          if (req_hs) begin
            periph_address <= req_addr;
            if (req_write) begin
              periph_din         <= req_wdata;
              periph_writeEnable <= 1'b1;
              resp_write         <= 1'b1;
              resp_rdata         <= 8'd0;
            end else begin
              resp_write <= 1'b0;
              cnt        <= LAT_M1;
            end
          end
        end
        READ: begin
          if (cnt_zero) resp_rdata <= periph_dout;
          else          cnt        <= cnt - 4'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_periph_bus_initiator.sv
// Directed bench for periph_bus_initiator with a transaction-level model and
// a per-cycle compare, plus literal expectations for each scenario.
module tb_periph_bus_initiator;

  localparam int LAT = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic       req_valid, req_ready, req_write;
  logic [3:0] req_addr;
  logic [7:0] req_wdata;
  logic       resp_valid, resp_ready, resp_write;
  logic [7:0] resp_rdata;
  logic [3:0] periph_address;
  logic [7:0] periph_din;
  logic       periph_writeEnable;
  logic [7:0] periph_dout;

  int checks   = 0;
  int failures = 0;

  periph_bus_initiator #(.READ_LATENCY(LAT)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_write(resp_write), .resp_rdata(resp_rdata),
    .periph_address(periph_address), .periph_din(periph_din),
    .periph_writeEnable(periph_writeEnable), .periph_dout(periph_dout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: actual=%0h expected=%0h", name, $time, act, exp);
    end
  endtask

  // ---------------- transaction-level model ----------------
  // bus_left: cycles of bus activity still owed to the accepted request;
  // pend: a response is waiting for the CPU.
  int         bus_left = 0;
  bit         pend     = 0;
  bit         is_wr    = 0;
  bit         chk_en   = 0;
  logic [3:0] m_addr   = 0;
  logic [7:0] m_din    = 0;
  logic [7:0] m_rdata  = 0;
  bit         m_rwrite = 0;

  always @(posedge clk) begin
    if (reset) begin
      bus_left = 0; pend = 0; is_wr = 0;
      m_addr = 0; m_din = 0; m_rdata = 0; m_rwrite = 0;
      chk_en = 1;
    end else if (bus_left == 0 && !pend) begin
      if (req_valid) begin
        m_addr = req_addr;
        is_wr  = req_write;
        if (req_write) begin
          m_din = req_wdata; m_rwrite = 1; m_rdata = 0; bus_left = 1;
        end else begin
          m_rwrite = 0; bus_left = LAT;
        end
      end
    end else if (bus_left > 0) begin
      if (bus_left == 1) begin
        if (!is_wr) m_rdata = periph_dout;
        pend = 1;
      end
      bus_left--;
    end else if (resp_ready) begin
      pend = 0;
    end
  end

  // ---------------- per-cycle compare ----------------
  int we_pulses = 0;
  bit prev_we   = 0;

  always @(negedge clk) begin
    if (chk_en) begin
      chk("req_ready",  req_ready,  (bus_left == 0 && !pend && !reset));
      chk("resp_valid", resp_valid, pend);
      chk("we",         periph_writeEnable, (bus_left > 0 && is_wr));
      chk("address",    periph_address, m_addr);
      chk("din",        periph_din, m_din);
      chk("resp_write", resp_write, m_rwrite);
      chk("resp_rdata", resp_rdata, m_rdata);
      if (prev_we) chk("we_back_to_back", periph_writeEnable, 1'b0);
      prev_we = periph_writeEnable;
      if (periph_writeEnable === 1'b1) we_pulses++;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic issue(input logic wr, input logic [3:0] a, input logic [7:0] d);
    req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = d;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    reset = 1'b1; req_valid = 0; req_write = 0; req_addr = 0; req_wdata = 0;
    resp_ready = 0; periph_dout = 0;
    step(); step();
    chk("rst_req_ready", req_ready, 1'b0);
    chk("rst_resp_valid", resp_valid, 1'b0);
    chk("rst_we", periph_writeEnable, 1'b0);
    chk("rst_addr", periph_address, 4'd0);
    chk("rst_rdata", resp_rdata, 8'd0);
    reset = 1'b0;
    #1 chk("rst_release_ready", req_ready, 1'b1);

    // 1) write addr 4, data 65; resp_ready already high
    resp_ready = 1'b1;
    issue(1'b1, 4'd4, 8'd65);
    step(); req_valid = 0;
    chk("t1_we", periph_writeEnable, 1'b1);
    chk("t1_addr", periph_address, 4'd4);
    chk("t1_din", periph_din, 8'd65);
    chk("t1_no_resp_yet", resp_valid, 1'b0);
    step();
    chk("t1_resp_valid", resp_valid, 1'b1);
    chk("t1_resp_write", resp_write, 1'b1);
    chk("t1_we_low", periph_writeEnable, 1'b0);
    step();
    chk("t1_idle", resp_valid, 1'b0);
    chk("t1_ready", req_ready, 1'b1);

    // 2) read addr 0, dout 50
    periph_dout = 8'd50;
    issue(1'b0, 4'd0, 8'hEE);
    step(); req_valid = 0;
    chk("t2_addr", periph_address, 4'd0);
    chk("t2_we", periph_writeEnable, 1'b0);
    chk("t2_din_held", periph_din, 8'd65);
    step(); step();
    chk("t2_not_yet", resp_valid, 1'b0);
    step();
    chk("t2_resp_valid", resp_valid, 1'b1);
    chk("t2_rdata", resp_rdata, 8'd50);
    chk("t2_resp_write", resp_write, 1'b0);
    step();
    chk("t2_done", resp_valid, 1'b0);
    chk("t2_rdata_held", resp_rdata, 8'd50);

    // 3) back-pressure on a read response
    resp_ready = 1'b0;
    periph_dout = 8'h5A;
    issue(1'b0, 4'd7, 8'h00);
    step(); req_valid = 0;
    repeat (3) step();
    for (int i = 0; i < 5; i++) begin
      chk("t3_valid_held", resp_valid, 1'b1);
      chk("t3_rdata_held", resp_rdata, 8'h5A);
      chk("t3_ready_low", req_ready, 1'b0);
      periph_dout = 8'(i);
      step();
    end
    resp_ready = 1'b1;
    step();
    chk("t3_released", resp_valid, 1'b0);
    chk("t3_rdata_kept", resp_rdata, 8'h5A);

    // 4) req_valid held: write then read back-to-back
    issue(1'b1, 4'd2, 8'h33);
    step();
    req_write = 1'b0; req_addr = 4'd9;
    chk("t4_we", periph_writeEnable, 1'b1);
    chk("t4_addr_w", periph_address, 4'd2);
    chk("t4_busy", req_ready, 1'b0);
    step();
    chk("t4_resp", resp_valid, 1'b1);
    chk("t4_busy2", req_ready, 1'b0);
    step();
    chk("t4_idle_ready", req_ready, 1'b1);
    chk("t4_addr_hold", periph_address, 4'd2);
    step(); req_valid = 0;
    chk("t4_addr_r", periph_address, 4'd9);
    chk("t4_we_r", periph_writeEnable, 1'b0);
    chk("t4_din_keep", periph_din, 8'h33);
    repeat (3) step();
    chk("t4_read_resp", resp_valid, 1'b1);
    step();

    // 5) reset in the middle of a read
    periph_dout = 8'h11;
    issue(1'b0, 4'd5, 8'h00);
    step(); req_valid = 0;
    step();
    reset = 1'b1;
    step();
    chk("t5_addr0", periph_address, 4'd0);
    chk("t5_din0", periph_din, 8'd0);
    chk("t5_rdata0", resp_rdata, 8'd0);
    chk("t5_no_resp", resp_valid, 1'b0);
    chk("t5_ready_in_rst", req_ready, 1'b0);
    reset = 1'b0;
    #1 chk("t5_ready_after", req_ready, 1'b1);
    step(); step();
    chk("t5_still_no_resp", resp_valid, 1'b0);

    // 6) dout changes on the final READ cycle
    periph_dout = 8'd7;
    issue(1'b0, 4'hC, 8'h00);
    step(); req_valid = 0;
    step(); step();
    periph_dout = 8'd9;
    step();
    chk("t6_valid", resp_valid, 1'b1);
    chk("t6_rdata", resp_rdata, 8'd9);
    step(); step();

    chk("we_pulse_count", we_pulses, 2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
